// File: rtl/alu_rs_dispatch.sv
// Reservation station for the integer ALU: dual-CDB operand wakeup, one registered dispatch per cycle.
// Optional macro RS_AGE_SEL_EN selects oldest-ready dispatch; otherwise the lowest-index ready entry wins.
`ifndef ROB_SZ_LOG
`define ROB_SZ_LOG 4
`endif

module alu_rs_dispatch #(
    parameter int RS_SZ_LOG = 3,
    parameter int TAG_W     = `ROB_SZ_LOG + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             iss_vld,
    input  logic [3:0]       iss_op,
    input  logic [31:0]      iss_vj,
    input  logic [31:0]      iss_vk,
    input  logic [TAG_W-1:0] iss_qj,
    input  logic [TAG_W-1:0] iss_qk,
    input  logic             iss_qj_busy,
    input  logic             iss_qk_busy,
    input  logic [31:0]      iss_imm,
    input  logic [31:0]      iss_pc,
    input  logic [TAG_W-1:0] iss_rd,
    output logic             rs_full,
    input  logic             cdb_alu_vld,
    input  logic [TAG_W-1:0] cdb_alu_tag,
    input  logic [31:0]      cdb_alu_val,
    input  logic             cdb_lsb_vld,
    input  logic [TAG_W-1:0] cdb_lsb_tag,
    input  logic [31:0]      cdb_lsb_val,
    output logic             run_flg,
    output logic [TAG_W-1:0] rd_fr,
    output logic [31:0]      Vj,
    output logic [31:0]      Vk,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [3:0]       opcode
);

    localparam int RS_SZ = 1 << RS_SZ_LOG;

    typedef struct packed {
        logic             busy;
        logic [3:0]       op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic             qj_busy;
        logic             qk_busy;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [TAG_W-1:0] rd;
    } entry_t;

    entry_t                 ent_q [RS_SZ];
    entry_t                 ent_d [RS_SZ];
    logic [RS_SZ-1:0]       ready;
    logic                   any_ready;
    logic                   any_free;
    logic [RS_SZ_LOG-1:0]   sel_idx;
    logic [RS_SZ_LOG-1:0]   free_idx;
    logic                   run_d;

    logic                   run_flg_q;
    logic [TAG_W-1:0]       rd_fr_q;
    logic [31:0]            vj_q, vk_q, imm_q, pc_q;
    logic [3:0]             opcode_q;

    // Returns {still_pending, value}; the ALU bus wins if both buses carry the tag.
    function automatic logic [32:0] snoop(input logic pend, input logic [TAG_W-1:0] q,
                                          input logic [31:0] v);
        if (pend && cdb_alu_vld && cdb_alu_tag == q) return {1'b0, cdb_alu_val};
        if (pend && cdb_lsb_vld && cdb_lsb_tag == q) return {1'b0, cdb_lsb_val};
        return {pend, v};
    endfunction

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        ready    = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            ready[i] = ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
            if (!ent_q[i].busy) begin
                any_free = 1'b1;
                free_idx = RS_SZ_LOG'(i);
            end
        end
    end

    assign rs_full = !any_free;

`ifdef RS_AGE_SEL_EN
    logic [RS_SZ_LOG:0] age_q [RS_SZ];
    logic [RS_SZ_LOG:0] cnt_q;

    // Wrap-safe: a is older than b when a - b is negative in the counter's width.
    function automatic logic older(input logic [RS_SZ_LOG:0] a, input logic [RS_SZ_LOG:0] b);
        logic [RS_SZ_LOG:0] d;
        d = a - b;
        return d[RS_SZ_LOG];
    endfunction

    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (ready[i] && (!any_ready || older(age_q[i], age_q[sel_idx]))) begin
                any_ready = 1'b1;
                sel_idx   = RS_SZ_LOG'(i);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
            for (int i = 0; i < RS_SZ; i++) age_q[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                cnt_q <= '0;
            end else if (iss_vld && any_free) begin
                age_q[free_idx] <= cnt_q;
                cnt_q           <= cnt_q + 1'b1;
            end
        end
    end
`else
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_idx   = RS_SZ_LOG'(i);
            end
        end
    end
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ent_d = ent_q;
        run_d = 1'b0;
        if (rdy_in && flush_in) begin
            for (int i = 0; i < RS_SZ; i++) ent_d[i].busy = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (ent_q[i].busy) begin
                    {ent_d[i].qj_busy, ent_d[i].vj} = snoop(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
                    {ent_d[i].qk_busy, ent_d[i].vk} = snoop(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
                end
            end
            if (any_ready) begin
                ent_d[sel_idx].busy = 1'b0;
                run_d               = 1'b1;
            end
            // The free slot was free at start of cycle, so it never collides with the dispatched one.
            if (iss_vld && any_free) begin
                ent_d[free_idx].busy = 1'b1;
                ent_d[free_idx].op   = iss_op;
                ent_d[free_idx].qj   = iss_qj;
                ent_d[free_idx].qk   = iss_qk;
                ent_d[free_idx].imm  = iss_imm;
                ent_d[free_idx].pc   = iss_pc;
                ent_d[free_idx].rd   = iss_rd;
                {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = snoop(iss_qj_busy, iss_qj, iss_vj);
                {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = snoop(iss_qk_busy, iss_qk, iss_vk);
            end
        end
    end

    // NOTE: whole entries are reset, not only busy, so no X payload can ever reach the issue bundle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < RS_SZ; i++) ent_q[i] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            run_flg_q <= 1'b0;
            rd_fr_q   <= '0;
            vj_q      <= '0;
            vk_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            opcode_q  <= '0;
        end else begin
            run_flg_q <= run_d;
            if (run_d) begin
                rd_fr_q  <= ent_q[sel_idx].rd;
                vj_q     <= ent_q[sel_idx].vj;
                vk_q     <= ent_q[sel_idx].vk;
                imm_q    <= ent_q[sel_idx].imm;
                pc_q     <= ent_q[sel_idx].pc;
                opcode_q <= ent_q[sel_idx].op;
            end
        end
    end

    assign run_flg = run_flg_q;
    assign rd_fr   = rd_fr_q;
    assign Vj      = vj_q;
    assign Vk      = vk_q;
    assign imm     = imm_q;
    assign pc      = pc_q;
    assign opcode  = opcode_q;

endmodule

// File: tb/tb_alu_rs_dispatch.sv
// Self-checking bench for alu_rs_dispatch: slot-level behavioural model compared every cycle,
// plus directed vectors with literal expectations (ordering follows RS_AGE_SEL_EN when defined).
`ifndef ROB_SZ_LOG
`define ROB_SZ_LOG 4
`endif

module tb_alu_rs_dispatch;

    localparam int TAG_W = `ROB_SZ_LOG + 1;
    localparam int NSLOT = 8;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h1;

    logic             clk_in = 1'b0;
    logic             rst_n_in, rdy_in, flush_in, iss_vld;
    logic [3:0]       iss_op;
    logic [31:0]      iss_vj, iss_vk, iss_imm, iss_pc;
    logic [TAG_W-1:0] iss_qj, iss_qk, iss_rd;
    logic             iss_qj_busy, iss_qk_busy;
    logic             rs_full;
    logic             cdb_alu_vld, cdb_lsb_vld;
    logic [TAG_W-1:0] cdb_alu_tag, cdb_lsb_tag;
    logic [31:0]      cdb_alu_val, cdb_lsb_val;
    logic             run_flg;
    logic [TAG_W-1:0] rd_fr;
    logic [31:0]      Vj, Vk, imm, pc;
    logic [3:0]       opcode;

    alu_rs_dispatch dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .iss_vld(iss_vld), .iss_op(iss_op), .iss_vj(iss_vj), .iss_vk(iss_vk),
        .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_qj_busy(iss_qj_busy), .iss_qk_busy(iss_qk_busy),
        .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rd(iss_rd), .rs_full(rs_full),
        .cdb_alu_vld(cdb_alu_vld), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_vld(cdb_lsb_vld), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
        .run_flg(run_flg), .rd_fr(rd_fr), .Vj(Vj), .Vk(Vk), .imm(imm), .pc(pc), .opcode(opcode)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit               busy;
        logic [3:0]       op;
        logic [31:0]      vj, vk, imm, pc;
        logic [TAG_W-1:0] qj, qk, rd;
        bit               qjb, qkb;
        int               seq;
    } slot_t;

    slot_t            m [NSLOT];
    logic             e_run;
    logic [TAG_W-1:0] e_rd;
    logic [31:0]      e_vj, e_vk, e_imm, e_pc;
    logic [3:0]       e_op;
    int               pick, free_slot, seq_ctr;

    function automatic void wake(input logic [TAG_W-1:0] q, inout bit pend, inout logic [31:0] v);
        if (!pend) return;
        if (cdb_alu_vld && cdb_alu_tag == q) begin
            v = cdb_alu_val; pend = 1'b0;
        end else if (cdb_lsb_vld && cdb_lsb_tag == q) begin
            v = cdb_lsb_val; pend = 1'b0;
        end
    endfunction

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < NSLOT; i++) if (m[i].busy) n++;
        return n == NSLOT;
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NSLOT; i++) m[i].busy = 1'b0;
            e_run = 0; e_rd = '0; e_vj = '0; e_vk = '0; e_imm = '0; e_pc = '0; e_op = '0;
            seq_ctr = 0;
        end else if (!rdy_in) begin
            e_run = 1'b0;
        end else if (flush_in) begin
            for (int i = 0; i < NSLOT; i++) m[i].busy = 1'b0;
            e_run   = 1'b0;
            seq_ctr = 0;
        end else begin
            pick = -1;
            free_slot = -1;
            for (int i = 0; i < NSLOT; i++) begin
                if (m[i].busy && !m[i].qjb && !m[i].qkb) begin
`ifdef RS_AGE_SEL_EN
                    if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
                    if (pick < 0) pick = i;
`endif
                end
                if (!m[i].busy && free_slot < 0) free_slot = i;
            end
            for (int i = 0; i < NSLOT; i++) begin
                if (m[i].busy) begin
                    wake(m[i].qj, m[i].qjb, m[i].vj);
                    wake(m[i].qk, m[i].qkb, m[i].vk);
                end
            end
            if (pick >= 0) begin
                e_run = 1'b1;
                e_rd = m[pick].rd; e_vj = m[pick].vj; e_vk = m[pick].vk;
                e_imm = m[pick].imm; e_pc = m[pick].pc; e_op = m[pick].op;
                m[pick].busy = 1'b0;
            end else begin
                e_run = 1'b0;
            end
            if (iss_vld && free_slot >= 0) begin
                m[free_slot].busy = 1'b1;
                m[free_slot].op   = iss_op;
                m[free_slot].vj   = iss_vj;  m[free_slot].vk  = iss_vk;
                m[free_slot].qj   = iss_qj;  m[free_slot].qk  = iss_qk;
                m[free_slot].qjb  = iss_qj_busy;
                m[free_slot].qkb  = iss_qk_busy;
                m[free_slot].imm  = iss_imm; m[free_slot].pc  = iss_pc;
                m[free_slot].rd   = iss_rd;
                m[free_slot].seq  = seq_ctr;
                seq_ctr++;
                wake(m[free_slot].qj, m[free_slot].qjb, m[free_slot].vj);
                wake(m[free_slot].qk, m[free_slot].qkb, m[free_slot].vk);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_on = 1'b0;

    always @(negedge clk_in) begin
        if (chk_on && rst_n_in) begin
            check("run_flg", 32'(run_flg), 32'(e_run));
            check("rs_full", 32'(rs_full), 32'(model_full()));
            check("rd_fr",   32'(rd_fr),   32'(e_rd));
            check("Vj",      Vj,           e_vj);
            check("Vk",      Vk,           e_vk);
            check("imm",     imm,          e_imm);
            check("pc",      pc,           e_pc);
            check("opcode",  32'(opcode),  32'(e_op));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
        end
    endtask

    task automatic drive_issue(input logic [3:0] op, input int vj, input int vk,
                               input int qj, input int qjb, input int qk, input int qkb,
                               input int im, input int p, input int rd);
        iss_vld = 1'b1; iss_op = op;
        iss_vj = 32'(vj); iss_vk = 32'(vk);
        iss_qj = TAG_W'(qj); iss_qj_busy = (qjb != 0);
        iss_qk = TAG_W'(qk); iss_qk_busy = (qkb != 0);
        iss_imm = 32'(im); iss_pc = 32'(p); iss_rd = TAG_W'(rd);
    endtask

    task automatic idle();
        iss_vld = 1'b0; cdb_alu_vld = 1'b0; cdb_lsb_vld = 1'b0;
    endtask

    task automatic drive_alu(input int tag, input int val);
        cdb_alu_vld = 1'b1; cdb_alu_tag = TAG_W'(tag); cdb_alu_val = 32'(val);
    endtask

    task automatic drive_lsb(input int tag, input int val);
        cdb_lsb_vld = 1'b1; cdb_lsb_tag = TAG_W'(tag); cdb_lsb_val = 32'(val);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        iss_op = '0; iss_vj = '0; iss_vk = '0; iss_qj = '0; iss_qk = '0;
        iss_qj_busy = 1'b0; iss_qk_busy = 1'b0; iss_imm = '0; iss_pc = '0; iss_rd = '0;
        cdb_alu_tag = '0; cdb_alu_val = '0; cdb_lsb_tag = '0; cdb_lsb_val = '0;
        idle();
        tick(2);
        rst_n_in = 1'b1;
        chk_on = 1'b1;
        check("reset run_flg", 32'(run_flg), 32'd0);
        check("reset rs_full", 32'(rs_full), 32'd0);
        check("reset Vj", Vj, 32'd0);

        // Ready ADDI: dispatched on the edge after the issue edge, gone the cycle after.
        drive_issue(OP_ADDI, 5, 0, 0, 0, 0, 0, 7, 32'h100, 3);
        tick(); idle(); tick();
        check("addi run_flg", 32'(run_flg), 32'd1);
        check("addi rd_fr", 32'(rd_fr), 32'd3);
        check("addi Vj", Vj, 32'd5);
        check("addi imm", imm, 32'd7);
        check("addi opcode", 32'(opcode), 32'(OP_ADDI));
        tick();
        check("addi run_flg after", 32'(run_flg), 32'd0);

        // Wakeup via LSB bus two cycles after issue; run_flg two edges after the CDB.
        drive_issue(OP_ADD, 0, 1, 2, 1, 0, 0, 0, 32'h104, 4);
        tick(); idle(); tick();
        drive_lsb(2, 32'h10);
        tick(); idle();
        check("wake not early", 32'(run_flg), 32'd0);
        tick();
        check("wake run_flg", 32'(run_flg), 32'd1);
        check("wake Vj", Vj, 32'h10);
        check("wake Vk", Vk, 32'd1);
        check("wake rd_fr", 32'(rd_fr), 32'd4);

        // Issue bypass from the ALU bus in the issue cycle.
        drive_issue(OP_SUB, 20, 0, 0, 0, 4, 1, 0, 32'h108, 6);
        drive_alu(4, 9);
        tick(); idle(); tick();
        check("bypass run_flg", 32'(run_flg), 32'd1);
        check("bypass Vk", Vk, 32'd9);
        check("bypass opcode", 32'(opcode), 32'(OP_SUB));

        // Pause holds a ready op; a CDB seen while paused is lost.
        drive_issue(OP_ADD, 3, 4, 0, 0, 0, 0, 0, 32'h10c, 7);
        tick(); idle(); rdy_in = 1'b0; tick();
        check("pause run_flg", 32'(run_flg), 32'd0);
        rdy_in = 1'b1; tick();
        check("resume rd_fr", 32'(rd_fr), 32'd7);
        drive_issue(OP_ADD, 0, 2, 9, 1, 0, 0, 0, 32'h110, 8);
        tick(); idle(); rdy_in = 1'b0; drive_alu(9, 32'h55); tick();
        rdy_in = 1'b1; idle(); tick(2);
        check("paused cdb dropped", 32'(run_flg), 32'd0);
        drive_alu(9, 32'h66); tick(); idle(); tick();
        check("late wake Vj", Vj, 32'h66);

        // Ordering: a ready younger op overtakes a waiting older one.
        drive_issue(OP_ADD, 0, 1, 5, 1, 0, 0, 0, 32'h200, 10);
        tick();
        drive_issue(OP_ADD, 2, 3, 0, 0, 0, 0, 0, 32'h204, 11);
        tick(); idle(); tick();
        check("order B first", 32'(rd_fr), 32'd11);
        drive_alu(5, 32'h77); tick(); idle(); tick();
        check("order A next", 32'(rd_fr), 32'd10);
        check("order A Vj", Vj, 32'h77);

        // Simultaneous wake of an older entry at a higher index and a younger one at slot 0.
        drive_issue(OP_ADD, 1, 1, 0, 0, 0, 0, 0, 32'h300, 12);
        tick();
        drive_issue(OP_ADD, 0, 1, 6, 1, 0, 0, 0, 32'h304, 13);
        tick();
        check("x dispatched", 32'(rd_fr), 32'd12);
        drive_issue(OP_ADD, 0, 2, 6, 1, 0, 0, 0, 32'h308, 14);
        tick(); idle(); drive_lsb(6, 32'h99); tick(); idle(); tick();
`ifdef RS_AGE_SEL_EN
        check("age first", 32'(rd_fr), 32'd13);
        tick();
        check("age second", 32'(rd_fr), 32'd14);
`else
        check("index first", 32'(rd_fr), 32'd14);
        tick();
        check("index second", 32'(rd_fr), 32'd13);
`endif

        // Fill all eight slots, ninth issue ignored, partial drain then flush.
        for (int i = 0; i < NSLOT; i++) begin
            drive_issue(OP_ADD, 0, i, 7, 1, 0, 0, 0, 32'h400 + 4 * i, i);
            tick();
        end
        check("full", 32'(rs_full), 32'd1);
        drive_issue(OP_ADDI, 1, 1, 0, 0, 0, 0, 0, 32'h500, 15);
        tick(); idle();
        check("still full", 32'(rs_full), 32'd1);
        tick();
        check("ninth ignored", 32'(run_flg), 32'd0);
        drive_alu(7, 32'hAB); tick(); idle(); tick();
        check("drain 0", 32'(rd_fr), 32'd0);
        check("drain Vj", Vj, 32'hAB);
        tick();
        check("drain 1", 32'(rd_fr), 32'd1);
        flush_in = 1'b1; tick(); flush_in = 1'b0;
        check("flush run_flg", 32'(run_flg), 32'd0);
        check("flush rs_full", 32'(rs_full), 32'd0);
        tick(3);
        check("post flush idle", 32'(run_flg), 32'd0);

        // Mid-run asynchronous reset discards a full station immediately.
        for (int i = 0; i < NSLOT; i++) begin
            drive_issue(OP_SUB, 0, i, 3, 1, 0, 0, 0, 32'h600 + 4 * i, i);
            tick();
        end
        idle();
        check("refill full", 32'(rs_full), 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check("async rst rs_full", 32'(rs_full), 32'd0);
        check("async rst run_flg", 32'(run_flg), 32'd0);
        tick();
        rst_n_in = 1'b1;
        drive_alu(3, 32'h1234); tick(); idle(); tick(2);
        check("no dispatch after reset", 32'(run_flg), 32'd0);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
